// File: rtl/msk_rnd_pkg.sv
// msk_rnd_pkg: shared sizing helpers and round-robin pick for the masking randomness scheduler.
package msk_rnd_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int RND_W_DEF = 2;
  localparam int REF_N_RND_DEF = 4;
  function automatic int k_of(int ref_n, int rnd_w);
    return ref_n / rnd_w;
  endfunction
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit cfg_ok(int n_req, int ref_n, int rnd_w);
    return rnd_w > 0 && ref_n >= rnd_w && ref_n % rnd_w == 0 && n_req >= 2 && n_req <= 16;
  endfunction
  localparam int K_DEF = k_of(REF_N_RND_DEF, RND_W_DEF);
  localparam int BC_W_DEF = cnt_w(K_DEF);
  localparam int PTR_W_DEF = cnt_w(N_REQ_DEF);
  // Returns {found, index} of the first set request at or after ptr, wrapping at n-1.
  function automatic logic [4:0] rr_pick(logic [15:0] req, logic [3:0] ptr, int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !r[4] && req[idx]) r = {1'b1, 4'(idx)};
    end
    return r;
  endfunction
endpackage

// File: rtl/msk_rnd_word_fifo.sv
// msk_rnd_word_fifo: 2-entry word FIFO that clears every entry as it is popped.
module msk_rnd_word_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rd, wr, push_ok, pop_ok;
  assign pop_ok = pop && count != 2'd0;
  assign push_ok = push && (count != 2'd2 || pop_ok);
  assign head = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      wr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr] <= push_data;
        wr <= !wr;
      end
      if (pop_ok) begin
        mem[rd] <= '0;
        rd <= !rd;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
endmodule

// File: rtl/msk_rnd_sched.sv
// msk_rnd_sched: packs PRNG beats into refresh words and grants each word once, round-robin.
// Optional MSK_RND_SCHED_STARVE_CNT_EN adds a saturating starvation counter output.
module msk_rnd_sched
  import msk_rnd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int RND_W = 2,
  parameter int REF_N_RND = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prng_valid,
  input  logic [RND_W-1:0]     prng_data,
  output logic                 prng_ready,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     gnt,
  output logic [REF_N_RND-1:0] rnd_out,
  output logic [1:0]           words_avail
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
  ,output logic [15:0]         starve_cnt
`endif
);
  localparam int K = k_of(REF_N_RND, RND_W);
  localparam int BC_W = cnt_w(K);
  localparam int PTR_W = cnt_w(N_REQ);
  if (!cfg_ok(N_REQ, REF_N_RND, RND_W)) begin : g_cfg_err
    $error("msk_rnd_sched: REF_N_RND must be a multiple of RND_W and N_REQ within 2..16");
  end
  logic [BC_W-1:0] beat_cnt;
  logic [REF_N_RND-1:0] asm_q, word, head;
  logic [PTR_W-1:0] rr_ptr;
  logic [1:0] count;
  logic [4:0] pick;
  logic last, accept, push, pop;
  assign last = beat_cnt == BC_W'(K - 1);
  assign prng_ready = !(last && count == 2'd2);
  assign accept = prng_valid && prng_ready;
  assign push = accept && last;
  assign pick = rr_pick(16'(req), 4'(rr_ptr), N_REQ);
  assign pop = count != 2'd0 && pick[4];
  assign words_avail = count;
  always_comb begin
    word = asm_q;
    word[int'(beat_cnt) * RND_W +: RND_W] = prng_data;
  end
  msk_rnd_word_fifo #(.W(REF_N_RND)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(word),
    .pop(pop),
    .head(head),
    .count(count)
  );
  // A completed word leaves the assembly register zeroed so no bit lingers after hand-off.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat_cnt <= '0;
      asm_q <= '0;
      rr_ptr <= '0;
      gnt <= '0;
      rnd_out <= '0;
    end else begin
      if (accept) begin
        beat_cnt <= last ? '0 : beat_cnt + BC_W'(1);
        asm_q <= last ? '0 : word;
      end
      gnt <= pop ? N_REQ'(1) << pick[3:0] : '0;
      rnd_out <= pop ? head : '0;
      if (pop) rr_ptr <= PTR_W'((int'(pick[3:0]) + 1) % N_REQ);
    end
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (|req && count == 2'd0 && starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_msk_rnd_sched.sv
// tb_msk_rnd_sched: randomized and directed checks against a queue-based reference model.
module tb_msk_rnd_sched;
  localparam int N = 4;
  localparam int RW = 2;
  localparam int RN = 4;
  localparam int K = RN / RW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prng_valid = 1'b0;
  logic [RW-1:0] prng_data = '0;
  logic prng_ready;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [RN-1:0] rnd_out;
  logic [1:0] words_avail;
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
  logic [15:0] starve_cnt;
`endif
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] part[$];
  logic [RN-1:0] fq[$];
  int rr = 0;
  int starve_m = 0;

  msk_rnd_sched #(.N_REQ(N), .RND_W(RW), .REF_N_RND(RN)) dut (
    .clk(clk),
    .rst(rst),
    .prng_valid(prng_valid),
    .prng_data(prng_data),
    .prng_ready(prng_ready),
    .req(req),
    .gnt(gnt),
    .rnd_out(rnd_out),
    .words_avail(words_avail)
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
    ,.starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; asserts reset with no clock edge in between and checks outputs at once.
  task automatic do_reset();
    prng_valid = 1'b0;
    req = '0;
    rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rnd", rnd_out, 0);
    chk("rst_avail", words_avail, 0);
    chk("rst_ready", prng_ready, 1);
    part.delete();
    fq.delete();
    rr = 0;
    starve_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the rising edge.
  task automatic step(input bit v, input logic [RW-1:0] d, input logic [N-1:0] r);
    bit rdy, empty;
    int win;
    logic [N-1:0] eg;
    logic [RN-1:0] er, w;
    prng_valid = v;
    prng_data = d;
    req = r;
    rdy = !(part.size() == K - 1 && fq.size() == 2);
    empty = fq.size() == 0;
    #1;
    chk("prng_ready", prng_ready, rdy);
    eg = '0;
    er = '0;
    win = -1;
    if (!empty)
      for (int i = 0; i < N; i++)
        if (win < 0 && r[(rr + i) % N]) win = (rr + i) % N;
    if (win >= 0) begin
      eg[win] = 1'b1;
      er = fq.pop_front();
      rr = (win + 1) % N;
    end
    if (r != 0 && empty && starve_m < 16'hFFFF) starve_m++;
    if (v && rdy) begin
      part.push_back(d);
      if (part.size() == K) begin
        w = '0;
        foreach (part[i]) w[i*RW +: RW] = part[i];
        fq.push_back(w);
        part.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("gnt", gnt, eg);
    chk("rnd_out", rnd_out, er);
    chk("words_avail", words_avail, fq.size());
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
    chk("starve_cnt", starve_cnt, starve_m);
`endif
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // Two beats form 4'b1001; the grant follows one cycle after the word is stored.
    step(1, 2'b01, 4'b0001);
    step(1, 2'b10, 4'b0001);
    chk("tp1_pre_gnt", gnt, 0);
    chk("tp1_pre_rnd", rnd_out, 0);
    step(0, 2'b00, 4'b0001);
    chk("tp1_gnt", gnt, 4'b0001);
    chk("tp1_rnd", rnd_out, 4'b1001);
    step(0, 2'b00, 4'b0001);
    chk("tp1_post_rnd", rnd_out, 0);
    do_reset();
    for (int i = 0; i < 12; i++) step(1, RW'($urandom), 4'b1111);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, RW'($urandom), 4'b0000);
    chk("tp3_full", words_avail, 2);
    chk("tp3_ready_low", prng_ready, 0);
    step(1, 2'b11, 4'b0000);
    step(1, 2'b11, 4'b0001);
    chk("tp3_ready_back", prng_ready, 1);
    step(1, 2'b11, 4'b0000);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, RW'($urandom), 4'b0000);
    for (int i = 0; i < 10; i++) step(1, RW'($urandom), 4'b0100);
    do_reset();
    step(1, 2'b01, 4'b0000);
    step(1, 2'b01, 4'b0000);
    step(1, 2'b10, 4'b0000);
    do_reset();
    step(1, 2'b11, 4'b0010);
    step(1, 2'b00, 4'b0010);
    step(0, 2'b00, 4'b0010);
    chk("tp5_post_rst_word", rnd_out, 4'b0011);
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 2'b00, 4'b0010);
`ifdef MSK_RND_SCHED_STARVE_CNT_EN
    chk("tp6_starve", starve_cnt, 10);
`endif
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, RW'($urandom),
           $urandom_range(0, 3) == 0 ? N'(0) : N'($urandom));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) != 0, RW'($urandom),
           $urandom_range(0, 4) == 0 ? N'(1) << $urandom_range(0, N - 1) : N'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
